program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//   Fetch/dispatch controller for the MC14500B core. Owns the program counter.
//   Runs the start-up hold on icu_reset and fetches instructions from program
//   ROM over a req/ack handshake. Dispatches each instruction to the ICU and
//   sequences JMP/RTN/SKZ/FLAG-F control flow from the ICU's completion flags.
// PARAMETERS
//   ADDR_W          8  program counter / ROM address width
//   STARTUP_CYCLES  2  clocks icu_reset is held after reset release (>=1)
//   STACK_DEPTH     4  return-stack entries (used only with SEQ_RETURN_STACK_EN)
// PORTS
//   clk          in   1       system clock, all state on posedge
//   reset_n      in   1       asynchronous reset, active-low
//   run          in   1       1 = allowed to start a new fetch
//   mem_req      out  1       ROM read request
//   mem_addr     out  ADDR_W  ROM address, stable while mem_req=1
//   mem_ack      in   1       ROM data valid this cycle (ends request)
//   mem_rdata    in   8       instruction word {opcode[7:4], io_addr[3:0]}
//   instr        out  8       instruction presented to ICU
//   instr_valid  out  1       one-cycle dispatch strobe
//   icu_reset    out  1       ICU reset hold
//   icu_done     in   1       ICU finished executing the dispatched instr
//   flag_jmp     in   1       executed JMP (qualified by icu_done)
//   flag_rtn     in   1       executed RTN
//   flag_skip    in   1       SKZ taken (RR=0)
//   flag_f       in   1       FLAG-F: halt request
//   jmp_target   in   ADDR_W  JMP destination, valid with flag_jmp
//   halted       out  1       sticky halt indicator
//   stack_err    out  1       sticky return-stack over/underflow
// BEHAVIOUR
// - Reset (async, reset_n=0): state=STARTUP, pc=0, cnt=0, skip_pend=0.
//   Outputs: mem_req=0, mem_addr=0, instr=0, instr_valid=0, icu_reset=1,
//   halted=0, stack_err=0. Mid-operation reset aborts at once; mem_req drops
//   asynchronously.
// - STARTUP: icu_reset=1; cnt counts up; after STARTUP_CYCLES clocks, go to
//   IDLE and set icu_reset=0.
// - IDLE: if run=1 -> FETCH next clock, else stay.
// - FETCH: mem_req=1, mem_addr=pc held until mem_ack.
//   - On ack with skip_pend=1: discard word, pc<=pc+1, skip_pend<=0, go IDLE.
//   - On ack with skip_pend=0: instr<=mem_rdata, go DISPATCH.
//   - mem_req falls the cycle after the ack.
// - DISPATCH: instr_valid=1 for exactly one cycle -> WAIT.
// - WAIT: ignore flags until icu_done=1, then resolve by priority
//   flag_f > flag_jmp > flag_rtn > flag_skip > sequential:
//   - f:    halted<=1 -> HALT.
//   - jmp:  pc<=jmp_target; push pc+1 if stack enabled.
//   - rtn:  see CONFIGURATION.
//   - skip: pc<=pc+1, skip_pend<=1.
//   - none: pc<=pc+1.
//   Every case except f goes to IDLE.
// - HALT: absorbing until reset. No mem_req, no dispatch.
// - pc arithmetic is modulo 2^ADDR_W (pc=max wraps to 0).
// - icu_done/flags outside WAIT are ignored. instr holds its last value.
// - Fetch-to-dispatch latency: instr_valid rises 1 clock after mem_ack.
// CONFIGURATION
//   SEQ_RETURN_STACK_EN defined:
//   - STACK_DEPTH-entry LIFO. JMP pushes pc+1 (after wrap). RTN pops into pc.
//   - Push when full: push dropped, stack_err<=1, jump still taken.
//   - Pop when empty: pc<=0, stack_err<=1.
//   SEQ_RETURN_STACK_EN undefined:
//   - No stack. JMP saves nothing.
//   - RTN behaves as native MC14500B: pc<=pc+1, skip_pend<=1.
//   - stack_err tied 0.
// TESTING
//   T1 reset_n low->high, STARTUP_CYCLES=2 -> icu_reset=1 for 2 clocks, then 0;
//      first mem_req with mem_addr=0 only after run=1.
//   T2 ROM 0x00=0x1A, ack after 3 wait states -> mem_addr=0 stable throughout;
//      instr=0x1A, one instr_valid pulse; done(no flags) -> next fetch addr 1.
//   T3 at pc=5: done+flag_skip -> addr 6 fetched and discarded, no
//      instr_valid; next dispatch comes from addr 7.
//   T4 at pc=3: done+flag_jmp, jmp_target=0x40 -> fetch 0x40. With macro:
//      later done+flag_rtn -> fetch 4. Without macro: rtn -> addr 0x41
//      skipped, fetch 0x42.
//   T5 pc=0xFF sequential -> next fetch addr 0x00. With macro: 5 nested JMPs
//      at depth 4 -> stack_err=1. RTN on empty stack -> fetch 0.
//   T6 done with flag_f=1 and flag_jmp=1 -> halted=1, no further mem_req;
//      reset_n low during FETCH -> mem_req=0 immediately.

Source files
------------

// File: rtl/program_sequencer_if.sv
// program_sequencer_if: ROM fetch bus plus ICU dispatch/completion signals of the MC14500B sequencer
interface program_sequencer_if #(parameter int ADDR_W = 8);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [7:0]        instr;
  logic              instr_valid;
  logic              icu_reset;
  logic              icu_done;
  logic              flag_jmp;
  logic              flag_rtn;
  logic              flag_skip;
  logic              flag_f;
  logic [ADDR_W-1:0] jmp_target;
  modport master (
    output mem_req, mem_addr, instr, instr_valid, icu_reset,
    input  mem_ack, mem_rdata, icu_done, flag_jmp, flag_rtn, flag_skip, flag_f, jmp_target
  );
  modport slave (
    input  mem_req, mem_addr, instr, instr_valid, icu_reset,
    output mem_ack, mem_rdata, icu_done, flag_jmp, flag_rtn, flag_skip, flag_f, jmp_target
  );
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: MC14500B fetch/dispatch controller; define SEQ_RETURN_STACK_EN for a JMP/RTN return stack
module program_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int STARTUP_CYCLES = 2,
  parameter int STACK_DEPTH    = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_run,
  program_sequencer_if.master bus,
  output logic                o_halted,
  output logic                o_stack_err
);
  localparam logic [2:0] STARTUP  = 3'd0;
  localparam logic [2:0] IDLE     = 3'd1;
  localparam logic [2:0] FETCH    = 3'd2;
  localparam logic [2:0] DISPATCH = 3'd3;
  localparam logic [2:0] WAIT     = 3'd4;
  localparam logic [2:0] HALT     = 3'd5;
  localparam int CNT_W = STARTUP_CYCLES > 1 ? $clog2(STARTUP_CYCLES) : 1;
  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc, w_pc_inc, w_rtn_pc;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_instr;
  logic              r_skip, w_rtn_skip;
  assign w_pc_inc        = r_pc + ADDR_W'(1);
  assign bus.mem_req     = r_state == FETCH;
  assign bus.mem_addr    = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_state == DISPATCH;
  assign bus.icu_reset   = r_state == STARTUP;
  assign o_halted        = r_state == HALT;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state <= STARTUP;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_skip  <= 1'b0;
      r_instr <= '0;
    end else begin
      case (r_state)
        STARTUP: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(STARTUP_CYCLES - 1)) r_state <= IDLE;
        end
        IDLE: if (i_run) r_state <= FETCH;
        FETCH: if (bus.mem_ack) begin
          // a pending skip consumes the fetched word without dispatching it
          r_state <= r_skip ? IDLE : DISPATCH;
          r_skip  <= 1'b0;
          if (r_skip) r_pc <= w_pc_inc;
          else r_instr <= bus.mem_rdata;
        end
        DISPATCH: r_state <= WAIT;
        WAIT: if (bus.icu_done) begin
          r_state <= bus.flag_f ? HALT : IDLE;
          if (!bus.flag_f) begin
            r_pc   <= bus.flag_jmp ? bus.jmp_target : bus.flag_rtn ? w_rtn_pc : w_pc_inc;
            r_skip <= !bus.flag_jmp && (bus.flag_rtn ? w_rtn_skip : bus.flag_skip);
          end
        end
        default: ;
      endcase
    end
`ifdef SEQ_RETURN_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic              r_err, w_full, w_empty, w_done, w_jmp, w_rtn;
  assign w_done      = r_state == WAIT && bus.icu_done && !bus.flag_f;
  assign w_jmp       = w_done && bus.flag_jmp;
  assign w_rtn       = w_done && !bus.flag_jmp && bus.flag_rtn;
  assign w_full      = r_sp == SP_W'(STACK_DEPTH);
  assign w_empty     = r_sp == '0;
  assign w_rtn_pc    = w_empty ? '0 : r_stack[IDX_W'(r_sp - SP_W'(1))];
  assign w_rtn_skip  = 1'b0;
  assign o_stack_err = r_err;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      if ((w_jmp && w_full) || (w_rtn && w_empty)) r_err <= 1'b1;
      if (w_jmp && !w_full) r_sp <= r_sp + SP_W'(1);
      if (w_rtn && !w_empty) r_sp <= r_sp - SP_W'(1);
    end
  always_ff @(posedge i_clk)
    if (w_jmp && !w_full) r_stack[IDX_W'(r_sp)] <= w_pc_inc;
`else
  // native MC14500B: RTN just skips the following word
  assign w_rtn_pc    = w_pc_inc;
  assign w_rtn_skip  = 1'b1;
  assign o_stack_err = 1'b0;
`endif
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed scoreboard bench for program_sequencer with a behavioural ROM/ICU
module tb_program_sequencer;
  logic clk = 1'b0, reset_n = 1'b0, run = 1'b0;
  logic halted, stack_err;
  int checks = 0, failures = 0;
  logic [7:0] q_addr[$], q_instr[$], m_stack[$];
  logic [7:0] m_pc = 8'h00, last_instr = 8'h00;
  bit m_skip = 0, m_halt = 0, m_err = 0;
  always #5 clk = ~clk;
  program_sequencer_if #(.ADDR_W(8)) bus();
  program_sequencer #(.ADDR_W(8), .STARTUP_CYCLES(2), .STACK_DEPTH(4)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_run(run), .bus(bus.master),
    .o_halted(halted), .o_stack_err(stack_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic fetch(input logic [7:0] data, input int waits, input bit disp);
    int n = 0;
    logic [7:0] a;
    q_addr.push_back(m_pc);
    while (bus.mem_req !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("fetch_timeout", n < 20, 1);
    a = q_addr.pop_front();
    chk("mem_addr", bus.mem_addr, a);
    repeat (waits) begin cyc(); chk("addr_stable", {bus.mem_req, bus.mem_addr}, {1'b1, a}); end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = data;
    if (disp) q_instr.push_back(data);
    cyc();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    chk("req_drop", bus.mem_req, 0);
    chk("instr_valid", bus.instr_valid, disp);
    if (disp) begin
      last_instr = q_instr.pop_front();
      chk("instr", bus.instr, last_instr);
      cyc();
      chk("valid_pulse", bus.instr_valid, 0);
    end else chk("instr_hold", bus.instr, last_instr);
  endtask
  task automatic step(input logic [7:0] data, input int waits, input bit f, input bit j,
                      input bit r, input bit s, input logic [7:0] tgt);
    if (m_skip) begin
      fetch(8'hEE, 0, 0);
      m_pc = m_pc + 8'd1;
      m_skip = 0;
    end
    fetch(data, waits, 1);
    {bus.flag_f, bus.flag_jmp, bus.flag_rtn, bus.flag_skip} = {f, j, r, s};
    bus.jmp_target = tgt;
    repeat (2) cyc();
    chk("flags_need_done", bus.mem_req, 0);
    bus.icu_done = 1'b1;
    cyc();
    bus.icu_done = 1'b0;
    {bus.flag_f, bus.flag_jmp, bus.flag_rtn, bus.flag_skip} = 4'b0;
    if (f) m_halt = 1;
    else if (j) begin
`ifdef SEQ_RETURN_STACK_EN
      if (m_stack.size() < 4) m_stack.push_back(m_pc + 8'd1);
      else m_err = 1;
`endif
      m_pc = tgt;
    end else if (r) begin
`ifdef SEQ_RETURN_STACK_EN
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_pc = 8'h00; m_err = 1; end
`else
      m_pc = m_pc + 8'd1;
      m_skip = 1;
`endif
    end else if (s) begin
      m_pc = m_pc + 8'd1;
      m_skip = 1;
    end else m_pc = m_pc + 8'd1;
    chk("halted", halted, m_halt);
    chk("stack_err", stack_err, m_err);
  endtask
  initial begin
    int n;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    bus.icu_done = 1'b0;
    {bus.flag_f, bus.flag_jmp, bus.flag_rtn, bus.flag_skip} = 4'b0;
    bus.jmp_target = 8'h00;
    repeat (2) cyc();
    chk("rst_icu_reset", bus.icu_reset, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stack_err", stack_err, 0);
    reset_n = 1'b1;
    cyc();
    chk("icu_reset_hold", bus.icu_reset, 1);
    cyc();
    chk("icu_reset_release", bus.icu_reset, 0);
    repeat (3) cyc();
    chk("no_req_without_run", bus.mem_req, 0);
    run = 1'b1;
    step(8'h1A, 3, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i < 5; i++) step(8'(8'h10 + i), i % 3, 0, 0, 0, 0, 8'h00);
    step(8'h25, 0, 0, 0, 0, 1, 8'h00);
    step(8'h37, 1, 0, 0, 0, 0, 8'h00);
    step(8'h48, 0, 0, 1, 0, 0, 8'h40);
    step(8'h50, 0, 0, 0, 1, 0, 8'h00);
    step(8'h60, 0, 0, 1, 0, 0, 8'hFF);
    step(8'h6F, 2, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(8'h70, 0, 0, 1, 0, 0, 8'(8'h80 + 8 * i));
    for (int i = 0; i < 6; i++) step(8'h90, 1, 0, 0, 1, 0, 8'h00);
    step(8'hF0, 0, 1, 1, 0, 0, 8'h10);
    repeat (10) cyc();
    chk("halt_no_req", bus.mem_req, 0);
    chk("halt_no_dispatch", bus.instr_valid, 0);
    chk("halt_sticky", halted, 1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("refetch_after_reset", bus.mem_req, 1);
    chk("refetch_addr", bus.mem_addr, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_req_drop", bus.mem_req, 0);
    chk("async_icu_reset", bus.icu_reset, 1);
    chk("async_halted_clear", halted, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
